// File: rtl/iccm_load_sequencer_if.sv
// ICCM port bundle: the sequencer drives the macro side and receives fetch requests
// from the TL-UL SRAM adapter.
interface iccm_load_sequencer_if #(
  parameter int AW = 12
);
  logic          fetch_req_i;
  logic [AW-1:0] fetch_addr_i;
  logic          fetch_gnt_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;

  modport master (
    input  fetch_req_i, fetch_addr_i,
    output fetch_gnt_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    output fetch_req_i, fetch_addr_i,
    input  fetch_gnt_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/iccm_load_sequencer.sv
// Boot loader for the ICCM: packs UART bytes / SPI words into sequential writes,
// then hands the port to the fetch path and releases the core.
module iccm_load_sequencer #(
  parameter int          AW       = 12,
  parameter logic [31:0] END_WORD = 32'h0000_0FFF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sel_i,
  input  logic                 rx_dv_i,
  input  logic [7:0]           rx_byte_i,
  input  logic                 spi_valid_i,
  input  logic [31:0]          spi_word_i,
  iccm_load_sequencer_if.master bus,
  output logic                 core_rst_no,
  output logic                 load_done_o,
  output logic                 load_err_o,
  output logic [AW:0]          word_cnt_o
);

  typedef enum logic [1:0] {S_LOAD, S_WRITE, S_RUN, S_ERR} state_e;

  state_e         state_q, state_d;
  logic [1:0]     idx_q, idx_d;
  logic [2:0][7:0] part_q, part_d;
  logic           sel_q;
  logic [AW:0]    cnt_q, cnt_d;
  logic [31:0]    slot_q, slot_d;

  logic           accept, sel_chg, cplt;
  logic [1:0]     idx_eff;
  logic [31:0]    cword;

  assign accept  = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign sel_chg = sel_i ^ sel_q;
  assign idx_eff = sel_chg ? 2'd0 : idx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_LOAD;
      idx_q   <= '0;
      part_q  <= '0;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      part_q  <= part_d;
      sel_q   <= sel_i;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_eff;
    part_d  = part_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    cplt    = 1'b0;
    cword   = spi_word_i;

    // Word assembly; a source switch restarts the byte index.
    if (accept) begin
      if (sel_i && rx_dv_i) begin
        if (idx_eff == 2'd3) begin
          cplt  = 1'b1;
          cword = {rx_byte_i, part_q};
        end else begin
          part_d[idx_eff] = rx_byte_i;
        end
        idx_d = idx_eff + 2'd1;
      end else if (!sel_i && spi_valid_i) begin
        cplt  = 1'b1;
        cword = spi_word_i;
      end
    end

    if (state_q == S_WRITE) cnt_d = cnt_q + (AW+1)'(1);

    // slot_q holds the word being written; a word arriving during WRITE becomes
    // the next write, so back-to-back words sustain one write per cycle.
    case (state_q)
      S_LOAD, S_WRITE: begin
        if (cplt) begin
          if (cword == END_WORD)  state_d = S_RUN;
          else if (cnt_d[AW])     state_d = S_ERR;
          else begin
            state_d = S_WRITE;
            slot_d  = cword;
          end
        end else if (state_q == S_WRITE) begin
          state_d = S_LOAD;
        end
      end
      default: ;
    endcase
  end

  logic run, wr;
  assign run = (state_q == S_RUN);
  assign wr  = (state_q == S_WRITE);

  assign bus.mem_req_o   = run ? bus.fetch_req_i  : wr;
  assign bus.mem_we_o    = wr;
  assign bus.mem_addr_o  = run ? bus.fetch_addr_i : (wr ? cnt_q[AW-1:0] : '0);
  assign bus.mem_wdata_o = wr ? slot_q : '0;
  assign bus.fetch_gnt_o = run & bus.fetch_req_i;

  assign core_rst_no = run;
  assign load_done_o = run;
  assign load_err_o  = (state_q == S_ERR);
  assign word_cnt_o  = cnt_q;

endmodule

// File: doc/iccm_load_sequencer.md
# iccm_load_sequencer

Boot-time owner of the instruction memory (ICCM) port. After reset it holds the core in reset and assembles program words from the UART programmer (byte stream) or the SPI slave (word stream). It writes each word to the ICCM at consecutive word addresses, then hands the ICCM read port to the TL-UL fetch path and releases the core. It sits between the UART receiver / SPI slave, the ICCM macro and the ICCM TL-UL SRAM adapter, replacing ad-hoc address/enable muxing at the top level.

## Interface
Parameters:
- AW, 12, ICCM word-address width (depth = 2^AW words)
- END_WORD, 32'h0000_0FFF, terminator word; ends loading and is never written

Ports:
- clk_i  in  1  system clock (only clock)
- rst_ni  in  1  asynchronous active-low reset
- sel_i  in  1  source select: 1 = UART bytes, 0 = SPI words
- rx_dv_i  in  1  UART byte valid, single-cycle pulse
- rx_byte_i  in  8  UART byte
- spi_valid_i  in  1  SPI word valid, single-cycle pulse
- spi_word_i  in  32  SPI word
- fetch_req_i  in  1  read request from TL-UL SRAM adapter
- fetch_addr_i  in  AW  read word address
- fetch_gnt_o  out  1  read grant
- mem_req_o  out  1  ICCM request
- mem_we_o  out  1  ICCM write enable
- mem_addr_o  out  AW  ICCM word address
- mem_wdata_o  out  32  ICCM write data
- core_rst_no  out  1  core reset, active-low
- load_done_o  out  1  loading finished, fetch path owns ICCM
- load_err_o  out  1  overflow error, sticky
- word_cnt_o  out  AW+1  words written so far

## Operation
- Reset values: all outputs 0 except core_rst_no = 0 (core held). Internal state: LOAD, byte index 0, write address 0, pending slot empty.
- States:
  - LOAD: accepting words. A completed word equal to END_WORD goes to RUN. Any other completed word goes to WRITE; if the address space is full, it goes to ERR instead.
  - WRITE: issues one write, then returns to LOAD, or stays in WRITE if a word is pending.
  - RUN: terminal until reset.
  - ERR: terminal until reset.
- UART assembly (sel_i = 1): bytes are packed little-endian; the first byte goes to [7:0] and the fourth to [31:24]. The word completes on the fourth rx_dv_i.
- SPI (sel_i = 0): each spi_valid_i pulse is one completed word, equal to spi_word_i.
- Inactive-source pulses are ignored. Any change of sel_i clears the byte index and discards the partial word.
- END_WORD is compared only on completed words. A partial UART word is never compared.
- WRITE cycle: mem_req_o = 1, mem_we_o = 1, mem_addr_o = write address, mem_wdata_o = word. The write address then increments and word_cnt_o increments.
- One-entry pending slot: a word completing while in WRITE is held and written in the next cycle. END_WORD held in the slot goes to RUN after the current write.
- Overflow: once word_cnt_o = 2^AW, any further non-END word goes to ERR. That word is not written, load_err_o = 1, and core_rst_no stays 0. Bytes and words received in ERR are ignored.
- RUN outputs:
  - core_rst_no = 1 and load_done_o = 1.
  - mem_req_o = fetch_req_i, mem_we_o = 0, mem_addr_o = fetch_addr_i, mem_wdata_o = 0.
  - fetch_gnt_o = fetch_req_i.
  - Loader inputs are ignored.
- Outside RUN: fetch_gnt_o = 0, and fetch requests never reach the ICCM.
- word_cnt_o never wraps. The write address is word_cnt_o[AW-1:0].

## Timing
- UART: 4th rx_dv_i at cycle N gives the write strobe at N+1.
- SPI: spi_valid_i at N gives the write strobe at N+1.
- END_WORD completing at N:
  - core_rst_no, load_done_o = 1 from N+1.
  - The fetch mux is active from N+1.
- All load-side outputs are registered.
- RUN fetch path is combinational, input to mem_*: zero cycles. ICCM read data and rvalid bypass this block.
- Back-to-back SPI words (every cycle) are sustained at one write per cycle via the pending slot.
- Asynchronous reset mid-write or in RUN:
  - Immediately mem_req_o = 0 and core_rst_no = 0.
  - All state returns to LOAD.
  - Written ICCM contents are not cleared.

## Test plan
- UART load: sel_i = 1, bytes 13 00 00 00, EF BE AD DE, FF 0F 00 00.
  - Writes: 0x00000013 at addr 0, then 0xDEADBEEF at addr 1.
  - After that: core_rst_no = 1 one cycle after the last byte, word_cnt_o = 2, no write of 0x00000FFF.
- SPI back-to-back: sel_i = 0, spi_valid_i on 3 consecutive cycles with 0x11, 0x22, END_WORD.
  - Writes: 0x11 at addr 0 at N+1, 0x22 at addr 1 at N+2.
  - load_done_o = 1 at N+3.
- Source switch: sel_i = 1, send 2 bytes, toggle sel_i to 0 and back to 1, then send AA BB CC DD.
  - Single write 0xDDCCBBAA at addr 0.
- Overflow: AW = 2, send 5 non-END SPI words.
  - Addrs 0–3 written, 5th not written.
  - load_err_o = 1, word_cnt_o = 4, core_rst_no stays 0, a following END_WORD is ignored.
- RUN fetch: after load, fetch_req_i = 1 with fetch_addr_i = 0x005.
  - Same cycle: mem_req_o = 1, mem_we_o = 0, mem_addr_o = 0x005, fetch_gnt_o = 1.
  - spi_valid_i pulses are ignored.
- Reset mid-load: assert rst_ni low during a WRITE cycle.
  - mem_req_o = 0 and core_rst_no = 0 asynchronously.
  - After release: word_cnt_o = 0, and the next word is written to addr 0.
